// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over req/ack, buffers into slot+skid.
// Optional perf counters are enabled with `define IF_FETCH_PERF_EN.
module if_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_data_i,
`ifdef IF_FETCH_PERF_EN
    output logic [31:0]       perf_fetch_cnt_o,
    output logic [31:0]       perf_flush_cnt_o,
`endif
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [ADDR_W-1:0] if_pc4_o,
    output logic [DATA_W-1:0] if_instr_o
);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {IDLE, FETCH, SKID, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, tgt_q, tgt_d;
    logic              slot_v_q, slot_v_d, skid_v_q, skid_v_d;
    logic [ADDR_W-1:0] slot_pc_q, slot_pc_d, skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] slot_ins_q, slot_ins_d, skid_ins_q, skid_ins_d;
    logic              consume;

    assign imem_req_o  = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr_o = addr_q;
    assign if_valid_o  = slot_v_q;
    assign if_pc_o     = slot_pc_q;
    assign if_pc4_o    = slot_pc_q + PC_STEP;
    assign if_instr_o  = slot_ins_q;
    // A redirect flushes the slot, so it is never counted as a hand-off to ID.
    assign consume     = slot_v_q && !stall_i && !redirect_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= RESET_PC;
            tgt_q      <= '0;
            slot_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            slot_pc_q  <= '0;
            skid_pc_q  <= '0;
            slot_ins_q <= '0;
            skid_ins_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tgt_q      <= tgt_d;
            slot_v_q   <= slot_v_d;
            skid_v_q   <= skid_v_d;
            slot_pc_q  <= slot_pc_d;
            skid_pc_q  <= skid_pc_d;
            slot_ins_q <= slot_ins_d;
            skid_ins_q <= skid_ins_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tgt_d      = tgt_q;
        slot_v_d   = slot_v_q;
        skid_v_d   = skid_v_q;
        slot_pc_d  = slot_pc_q;
        skid_pc_d  = skid_pc_q;
        slot_ins_d = slot_ins_q;
        skid_ins_d = skid_ins_q;
        if (redirect_i) begin
            slot_v_d = 1'b0;
            skid_v_d = 1'b0;
            // An outstanding request cannot be withdrawn: park the target until its ack.
            if (imem_req_o && !imem_ack_i) begin
                state_d = DRAIN;
                tgt_d   = redirect_pc_i;
            end else begin
                state_d = FETCH;
                addr_d  = redirect_pc_i;
            end
        end else begin
            if (consume) slot_v_d = 1'b0;
            unique case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (imem_ack_i) begin
                        addr_d = addr_q + PC_STEP;
                        if (!slot_v_q || consume) begin
                            slot_v_d   = 1'b1;
                            slot_pc_d  = addr_q;
                            slot_ins_d = imem_data_i;
                        end else begin
                            skid_v_d   = 1'b1;
                            skid_pc_d  = addr_q;
                            skid_ins_d = imem_data_i;
                            state_d    = SKID;
                        end
                    end
                end
                SKID: begin
                    if (consume) begin
                        slot_v_d   = 1'b1;
                        slot_pc_d  = skid_pc_q;
                        slot_ins_d = skid_ins_q;
                        skid_v_d   = 1'b0;
                        state_d    = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack_i) begin
                        addr_d  = tgt_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q, flush_inc;

    always_comb begin
        flush_inc = '0;
        if (redirect_i)
            flush_inc = 32'(slot_v_q) + 32'(skid_v_q) + 32'(imem_req_o && imem_ack_i);
        else if (state_q == DRAIN && imem_ack_i)
            flush_inc = 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'(consume);
            flush_cnt_q <= flush_cnt_q + flush_inc;
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the pipelined MIPS core; sits directly upstream of the IF/ID pipe register.
- Owns the program counter and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned instructions in a 2-entry output slot/skid so ID stalls never break a memory transaction.
- Honours branch/jump redirects from EX, discarding wrong-path fetches.

Parameters:
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width
RESET_PC, 0, first fetch address after reset

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  downstream not accepting this cycle (hazard unit)
redirect_i  in  1  taken branch/jump; next fetch from redirect_pc_i
redirect_pc_i  in  ADDR_W  redirect target
imem_req_o  out  1  fetch request
imem_addr_o  out  ADDR_W  fetch address, stable while req high
imem_ack_i  in  1  memory completes request; imem_data_i valid this cycle
imem_data_i  in  DATA_W  fetched instruction
if_valid_o  out  1  output slot holds an instruction
if_pc_o  out  ADDR_W  PC of slot instruction
if_pc4_o  out  ADDR_W  if_pc_o + 4
if_instr_o  out  DATA_W  slot instruction

Behaviour:
- Reset (async, rst_n=0): state IDLE; addr_q=RESET_PC; tgt_q=0; slot and skid invalid; all outputs 0 (if_instr_o=0, i.e. NOP); imem_req_o=0.
- States: IDLE, FETCH, SKID, DRAIN. imem_req_o = (state==FETCH || state==DRAIN); imem_addr_o = addr_q. Outputs are registered.
- IDLE: unconditionally -> FETCH on the next edge. First req is high in the 2nd cycle after reset release.
- Consume: slot is taken on any edge with if_valid_o=1 and stall_i=0.
- FETCH:
  - Ack with no redirect: instruction (pc=addr_q) goes to slot if slot is empty or consumed this edge, else to skid -> SKID. addr_q += 4 (mod 2^ADDR_W wrap).
  - No ack: hold addr_q.
  - Zero-wait ack (ack in first req cycle) allowed: back-to-back ack gives 1 instruction/cycle.
- SKID: req low.
  - When slot is consumed: skid moves to slot, skid is invalidated -> FETCH.
  - Skid full and slot full with stall held: stay.
- Redirect (priority over stall and ack), any state:
  - Slot and skid invalidated on that edge.
  - ack same cycle, or state SKID/IDLE: discard ack data; addr_q = redirect_pc_i; -> FETCH.
  - FETCH without ack: request outstanding, so req must not drop. tgt_q = redirect_pc_i; -> DRAIN.
  - DRAIN without ack: tgt_q updated (latest redirect wins).
- DRAIN: req high at old addr_q. On ack: data discarded; addr_q = tgt_q; -> FETCH.
- Invariants:
  - Never more than 2 buffered instructions.
  - req never drops, and addr never changes, before ack.
  - No instruction fetched before a redirect reaches if_valid_o after it.
- if_pc4_o: combinational if_pc_o+4, truncated to ADDR_W.

Optional Feature:
- Macro IF_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt_o and perf_flush_cnt_o (32 bits each, reset 0, wrap at 2^32).
  - perf_fetch_cnt_o: increments on every slot consume.
  - perf_flush_cnt_o: increments by the number of valid slot/skid entries discarded plus 1 per discarded ack data word.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset release, ack tied high, stall_i=0 -> cycle 2 req at addr 0; if_valid_o from cycle 3 with pc 0,4,8,... one per cycle; if_pc4_o = pc+4.
2. Stream running, stall_i high 3 cycles -> instr at 0x8 held in slot and 0xC in skid; req low while in SKID; after release 0x8, 0xC, 0x10 delivered in order, none lost or duplicated.
3. Ack delayed 2 cycles at addr 0x10, redirect_i to 0x100 in the first wait cycle -> req stays high at 0x10 until ack; that data is discarded; next req at 0x100; first valid pc is 0x100.
4. Redirect to 0x200 in the same cycle as ack of 0x20 -> 0x20 never appears; next req at 0x200.
5. Slot and skid full under stall, redirect to 0x40 -> both invalid next cycle; if_valid_o=0; req at 0x40.
6. Counters with IF_FETCH_PERF_EN defined, run scenario 5 -> perf_flush_cnt_o += 2; perf_fetch_cnt_o equals the number of consumed instructions.
